// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester-side and UART-side byte stream bundle for the
//               round-robin UART transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
    parameter int P_REQ_NUM    = 4,
    parameter int P_DATA_WIDTH = 8
);
    logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_req_data;
    logic [P_REQ_NUM-1:0]              i_req_valid;
    logic [P_REQ_NUM-1:0]              i_req_last;
    logic [P_REQ_NUM-1:0]              o_req_ready;
    logic [P_REQ_NUM-1:0]              o_grant;
    logic [P_DATA_WIDTH-1:0]           o_uart_tx_data;
    logic                              o_uart_tx_valid;
    logic                              i_uart_tx_ready;
    logic                              o_busy;

    // Arbiter side
    modport slave (
        input  i_req_data, i_req_valid, i_req_last, i_uart_tx_ready,
        output o_req_ready, o_grant, o_uart_tx_data, o_uart_tx_valid, o_busy
    );

    // Requesters and UART driver side
    modport master (
        output i_req_data, i_req_valid, i_req_last, i_uart_tx_ready,
        input  o_req_ready, o_grant, o_uart_tx_data, o_uart_tx_valid, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-granular round-robin arbiter sharing one UART transmit
//               byte stream between P_REQ_NUM requesters, with burst limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int P_REQ_NUM    = 4,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_MAX_BURST  = 16
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst,
    uart_tx_arbiter_if.slave    bus
);

    localparam int         C_IDX_W      = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
    localparam logic [7:0] C_BURST_LAST = 8'(P_MAX_BURST - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state_q,     state_d;
    logic [P_REQ_NUM-1:0] grant_q,     grant_d;
    logic [C_IDX_W-1:0]   gidx_q,      gidx_d;
    logic [C_IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;

    logic                    w_found;
    logic [C_IDX_W-1:0]      w_pick;
    logic [P_REQ_NUM-1:0]    w_pick_oh;
    logic                    w_tx_valid;
    logic [P_DATA_WIDTH-1:0] w_tx_data;
    logic [P_REQ_NUM-1:0]    w_req_ready;
    logic                    w_last;
    logic                    w_beat;
    logic                    w_release;

    // Scan upward from rr_ptr+1 so the previous winner is considered last.
    always_comb begin
        logic [C_IDX_W:0] cand;
        w_found   = 1'b0;
        w_pick    = '0;
        w_pick_oh = '0;
        cand      = '0;
        for (int k = 1; k <= P_REQ_NUM; k++) begin
            cand = {1'b0, rr_ptr_q} + (C_IDX_W+1)'(k);
            if (cand >= (C_IDX_W+1)'(P_REQ_NUM)) begin
                cand = cand - (C_IDX_W+1)'(P_REQ_NUM);
            end
            for (int n = 0; n < P_REQ_NUM; n++) begin
                if (!w_found && cand == (C_IDX_W+1)'(n) && bus.i_req_valid[n]) begin
                    w_found      = 1'b1;
                    w_pick       = C_IDX_W'(n);
                    w_pick_oh[n] = 1'b1;
                end
            end
        end
    end

    // Zero-latency pass-through of the granted requester.
    always_comb begin
        w_tx_valid  = 1'b0;
        w_tx_data   = '0;
        w_req_ready = '0;
        w_last      = 1'b0;
        for (int n = 0; n < P_REQ_NUM; n++) begin
            if (state_q == XFER && gidx_q == C_IDX_W'(n)) begin
                w_tx_valid     = bus.i_req_valid[n];
                w_tx_data      = bus.i_req_data[n*P_DATA_WIDTH +: P_DATA_WIDTH];
                w_req_ready[n] = bus.i_uart_tx_ready;
                w_last         = bus.i_req_last[n];
            end
        end
    end

    assign w_beat    = w_tx_valid & bus.i_uart_tx_ready;
    assign w_release = w_beat & (w_last | (burst_cnt_q == C_BURST_LAST));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    state_d     = XFER;
                    grant_d     = w_pick_oh;
                    gidx_d      = w_pick;
                    burst_cnt_d = '0;
                end
            end
            XFER: begin
                if (w_release) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    rr_ptr_d    = gidx_q;
                    burst_cnt_d = '0;
                end else if (w_beat) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= C_IDX_W'(P_REQ_NUM - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign bus.o_req_ready     = w_req_ready;
    assign bus.o_grant         = grant_q;
    assign bus.o_uart_tx_data  = w_tx_data;
    assign bus.o_uart_tx_valid = w_tx_valid;
    assign bus.o_busy          = (state_q == XFER);

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit user interface (data/valid/ready byte stream into the UART driver) between P_REQ_NUM requesters.
- Arbitration is round-robin at packet granularity. A grant is held until the requester's last byte is accepted, or until P_MAX_BURST bytes have been sent.
- Sits between user logic (command responders, loggers) and the UART driver's i_user_tx_* / o_user_tx_ready port, in the driver's user clock domain.

Parameters:
P_REQ_NUM, 4, number of requesters (2..8)
P_DATA_WIDTH, 8, byte width; must equal the UART driver data width
P_MAX_BURST, 16, max bytes per grant before forced rotation (1..255)

Ports:
i_clk  in  1  user clock (UART driver user clock)
i_rst  in  1  synchronous reset, active-low
i_req_data  in  P_REQ_NUM*P_DATA_WIDTH  requester n data at bits [n*P_DATA_WIDTH +: P_DATA_WIDTH]
i_req_valid  in  P_REQ_NUM  per-requester byte valid
i_req_last  in  P_REQ_NUM  per-requester last byte of packet, qualified by valid
o_req_ready  out  P_REQ_NUM  per-requester ready
o_grant  out  P_REQ_NUM  one-hot current grant; 0 when idle
o_uart_tx_data  out  P_DATA_WIDTH  to UART driver tx data
o_uart_tx_valid  out  1  to UART driver tx valid
i_uart_tx_ready  in  1  from UART driver tx ready
o_busy  out  1  1 while in XFER

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-low; all state is sampled on the i_clk rising edge while i_rst==0.
- Reset state:
  - state=IDLE, o_grant=0, rr_ptr=P_REQ_NUM-1 (so requester 0 wins first), burst_cnt=0.
  - o_req_ready=0, o_uart_tx_valid=0, o_uart_tx_data=0, o_busy=0.
- States: IDLE, XFER.
- IDLE:
  - All outputs are 0.
  - If any i_req_valid=1, pick the first valid index scanning upward from rr_ptr+1, wrapping modulo P_REQ_NUM.
  - Register the pick as a one-hot o_grant and go to XFER on the next edge.
  - Arbitration latency: 1 cycle from valid to grant. No byte is accepted in the arbitration cycle.
- XFER, with g = granted index (combinational pass-through, 0 added latency):
  - o_uart_tx_valid = i_req_valid[g]; o_uart_tx_data = data slice g.
  - o_req_ready[g] = i_uart_tx_ready; all other ready bits = 0.
  - o_busy=1.
- Beat = o_uart_tx_valid & i_uart_tx_ready. Each beat increments burst_cnt.
- Release condition: a beat with i_req_last[g]=1, or a beat where burst_cnt==P_MAX_BURST-1.
  - On release: state to IDLE, rr_ptr=g, burst_cnt=0, o_grant=0 on the next edge.
  - Minimum gap between grants is 1 idle cycle.
- Forced release (burst limit) does not mark the packet done. The same requester may re-win later; this is intentional starvation protection.
- Granted requester drops valid mid-packet: grant is held indefinitely with o_uart_tx_valid=0. There is no timeout.
- i_req_last without valid is ignored.
- Non-granted requesters never see ready=1 and are never consumed.
- Simultaneous requests: the lowest index at or after rr_ptr+1 wins. The previous winner has the lowest priority.
- rr_ptr updates only on release, never during IDLE.
- Reset asserted mid-packet: immediate return to reset state on that edge; the partial packet is abandoned, no ready or valid is asserted afterwards.
- burst_cnt width is 8 bits; it never exceeds P_MAX_BURST-1.
- Invariants:
  - o_grant is zero or one-hot.
  - o_req_ready has at most one bit set, and only the granted bit.
  - The downstream valid/data protocol is stable: once valid is high, data and valid hold until ready, provided the requester obeys the same rule.

Test Plan:
1. Reset with i_rst=0 for 5 cycles while all requesters are valid:
   - All outputs stay 0.
   - After release, the first grant is requester 0 (o_grant=4'b0001) exactly 1 cycle after i_rst rises.
2. All 4 requesters send 3-byte packets (req n bytes 0xn0..0xn2, last on the third) with i_uart_tx_ready held at 1:
   - Output order is 00,01,02,10,11,12,20,21,22,30,31,32.
   - Exactly 1 idle cycle between packets.
   - No interleaving.
3. Requester 1 sends a 40-byte packet with P_MAX_BURST=16 while requester 2 also requests:
   - Output is req1 bytes 0-15, then req2's packet, then req1 bytes 16-31, req2 if pending, then req1 bytes 32-39.
   - rr_ptr is checked after each release.
4. Backpressure: i_uart_tx_ready toggles randomly (about 30% high) during a 10-byte packet from requester 3:
   - Data and valid hold while ready=0.
   - Exactly 10 beats occur, in order, with no duplicates.
   - o_req_ready[3] mirrors i_uart_tx_ready, and the other ready bits stay 0.
5. Requester 0 drops valid for 20 cycles mid-packet while requester 1 is valid:
   - Grant stays with 0 and o_uart_tx_valid=0 during the gap.
   - The packet resumes, then requester 1 is granted after requester 0's last byte.
6. Assert i_rst=0 after byte 2 of a 5-byte packet:
   - The next cycle shows all outputs 0 and rr_ptr=3.
   - A new request is then served starting from requester 0.
   - Bench is connected to the UART driver at 9600 baud (50 MHz) to confirm the end-to-end serial byte order matches scenario 2.
